instruction_fetch_unit: RTL and testbench

//   Upstream neighbour of the control unit. Owns the PC, issues reads to instruction memory,
//   and buffers up to DEPTH prefetched 18-bit instructions. Presents the head instruction on
//   `instruction` and advances when the control unit pulses fetch. A jump redirects the PC and

---
 rtl/cpu_pkg.sv | 15 +
 rtl/instruction_fetch_unit_buffer.sv | 63 ++++++
 rtl/instruction_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and the fetch-state encoding.
// The control unit imports the same widths.
package cpu_pkg;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 18;
    localparam logic [ADDR_W-1:0] RESET_PC = 11'd0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_buffer.sv
// Prefetch FIFO of {instruction, pc} pairs; flush empties it and overrides push/pop.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     flush,
    input  logic                     push,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic [ADDR_W-1:0]        push_pc,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [INSTR_W-1:0]       head_instr,
    output logic [ADDR_W-1:0]        head_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_W-1:0] instr_mem_r [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    // Pointer, occupancy and storage update; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= {INSTR_W{1'b0}};
                pc_mem_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                instr_mem_r[wr_ptr_r] <= push_instr;
                pc_mem_r[wr_ptr_r]    <= push_pc;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count      = count_r;
    assign head_instr = instr_mem_r[rd_ptr_r];
    assign head_pc    = pc_mem_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues instruction-memory reads and prefetches into a
// small buffer consumed by the control unit; a jump redirects and flushes.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               fetch,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e       in_flight_ok_r;
    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic               imem_req_r;

    logic [CNT_W-1:0]   count_s;
    logic [CNT_W-1:0]   space_s;
    logic [INSTR_W-1:0] head_instr_s;
    logic [ADDR_W-1:0]  head_pc_s;
    logic               valid_s;
    logic               pop_s;
    logic               push_s;

    assign valid_s = (count_s != {CNT_W{1'b0}});
    assign pop_s   = fetch & valid_s & ~jump_en;
    assign push_s  = (in_flight_ok_r == S_BUSY) & imem_ack & ~jump_en;
    assign space_s = CNT_W'(DEPTH) - count_s + {{(CNT_W-1){1'b0}}, pop_s};

    fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clock      (clock),
        .clear      (clear),
        .flush      (jump_en),
        .push       (push_s),
        .push_instr (imem_rdata),
        .push_pc    (imem_addr_r),
        .pop        (pop_s),
        .count      (count_s),
        .head_instr (head_instr_s),
        .head_pc    (head_pc_s)
    );

    // Fetch FSM: request issue, back-to-back continuation, and discard of redirected reads.
    always_ff @(posedge clock) begin
        if (clear) begin
            in_flight_ok_r <= S_IDLE;
            imem_req_r     <= 1'b0;
            imem_addr_r    <= RESET_PC;
            fetch_pc_r     <= RESET_PC;
        end else begin
            case (in_flight_ok_r)
                S_IDLE: begin
                    if (jump_en) begin
                        fetch_pc_r <= jump_addr;
                    end else if (space_s != {CNT_W{1'b0}}) begin
                        imem_req_r     <= 1'b1;
                        imem_addr_r    <= fetch_pc_r;
                        in_flight_ok_r <= S_BUSY;
                    end else begin
                        imem_req_r <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (imem_ack && jump_en) begin
                        fetch_pc_r     <= jump_addr;
                        imem_req_r     <= 1'b0;
                        in_flight_ok_r <= S_IDLE;
                    end else if (imem_ack) begin
                        fetch_pc_r <= imem_addr_r + ADDR_W'(1);
                        // Room left after this push means the next read can go out at once.
                        if (space_s > CNT_W'(1)) begin
                            imem_addr_r <= imem_addr_r + ADDR_W'(1);
                        end else begin
                            imem_req_r     <= 1'b0;
                            in_flight_ok_r <= S_IDLE;
                        end
                    end else if (jump_en) begin
                        fetch_pc_r     <= jump_addr;
                        in_flight_ok_r <= S_DISCARD;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (jump_en) begin
                        fetch_pc_r <= jump_addr;
                    end
                    if (imem_ack) begin
                        imem_req_r     <= 1'b0;
                        in_flight_ok_r <= S_IDLE;
                    end
                end
                default: begin
                    imem_req_r     <= 1'b0;
                    in_flight_ok_r <= S_IDLE;
                end
            endcase
        end
    end

    // Head presentation: zeros while the buffer is empty.
    always_comb begin
        if (valid_s) begin
            instruction = head_instr_s;
            instr_pc    = head_pc_s;
        end else begin
            instruction = {INSTR_W{1'b0}};
            instr_pc    = {ADDR_W{1'b0}};
        end
    end

    assign instr_valid = valid_s;
    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, corner sequences,
// and a randomized run checked against an instruction-stream reference model.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        clear;
    logic        fetch;
    logic        jump_en;
    logic [10:0] jump_addr;
    logic [17:0] instruction;
    logic [10:0] instr_pc;
    logic        instr_valid;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic        imem_ack;
    logic [17:0] imem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    instruction_fetch_unit #(.DEPTH(2)) dut (
        .clock       (clock),
        .clear       (clear),
        .fetch       (fetch),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [17:0] word_of(input logic [10:0] a);
        return {7'd0, a} + 18'h00100;
    endfunction

    // Memory contents mem[i] = i + 0x100; garbage when not acking.
    assign imem_rdata = imem_ack ? word_of(imem_addr) : 18'h3FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic c, input logic f, input logic a, input logic j,
                        input logic [10:0] ja);
        clear = c; fetch = f; imem_ack = a; jump_en = j; jump_addr = ja;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_head(input string name, input logic v, input logic [10:0] pc);
        chk({name, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({name, ".pc"}, {21'd0, instr_pc}, v ? {21'd0, pc} : 32'd0);
        chk({name, ".instr"}, {14'd0, instruction}, v ? {14'd0, word_of(pc)} : 32'd0);
    endtask

    task automatic chk_req(input string name, input logic r, input logic [10:0] a);
        chk({name, ".req"}, {31'd0, imem_req}, {31'd0, r});
        chk({name, ".addr"}, {21'd0, imem_addr}, {21'd0, a});
    endtask

    typedef struct {
        logic        fetch;
        logic        ack;
        logic        exp_req;
        logic [10:0] exp_addr;
        logic        exp_valid;
        logic [10:0] exp_pc;
    } vec_t;

    vec_t vecs[12];

    logic [10:0] exp_pc;
    logic        prev_req, prev_ack;
    logic [10:0] prev_addr;
    logic        f_r, a_r, j_r;
    logic [10:0] ja_r;
    int          starve;

    initial begin
        // Prefetch two words with no fetch, then stream with fetch every cycle, then drain.
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 11'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 11'd1, 1'b1, 11'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 11'd1, 1'b1, 11'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 11'd1, 1'b1, 11'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 11'd2, 1'b1, 11'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 11'd3, 1'b1, 11'd2};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 11'd4, 1'b1, 11'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 11'd5, 1'b1, 11'd4};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 11'd5, 1'b1, 11'd4};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 11'd6, 1'b1, 11'd5};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 11'd6, 1'b0, 11'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 11'd6, 1'b0, 11'd0};

        clear = 1'b1; fetch = 1'b0; imem_ack = 1'b0; jump_en = 1'b0; jump_addr = 11'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
        chk_req("reset", 1'b0, 11'd0);
        chk_head("reset", 1'b0, 11'd0);

        for (int i = 0; i < 12; i++) begin
            step(1'b0, vecs[i].fetch, vecs[i].ack, 1'b0, 11'd0);
            chk_req($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr);
            chk_head($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
        end

        // Slow ack with a jump in the second wait cycle: request held, data dropped.
        step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        chk_req("slow.w1", 1'b1, 11'd6);
        step(1'b0, 1'b0, 1'b0, 1'b1, 11'h040);
        chk_req("slow.jump", 1'b1, 11'd6);
        chk_head("slow.jump", 1'b0, 11'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        chk_req("slow.w3", 1'b1, 11'd6);
        step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
        chk("slow.ack.req", {31'd0, imem_req}, 32'd0);
        chk_head("slow.ack", 1'b0, 11'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        chk_req("slow.reissue", 1'b1, 11'h040);
        step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
        chk_head("slow.first", 1'b1, 11'h040);

        // Jump to the top of memory while a read is pending, then stream across the wrap.
        step(1'b0, 1'b0, 1'b0, 1'b1, 11'h7FF);
        chk_head("wrap.jump", 1'b0, 11'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
        chk("wrap.discard.req", {31'd0, imem_req}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
        chk_req("wrap.req", 1'b1, 11'h7FF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
        chk_head("wrap.top", 1'b1, 11'h7FF);
        chk_req("wrap.next", 1'b1, 11'h000);
        step(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
        chk_head("wrap.zero", 1'b1, 11'h000);

        // Jump, ack and fetch together: acked word never appears.
        step(1'b0, 1'b1, 1'b1, 1'b1, 11'h123);
        chk_head("same.flush", 1'b0, 11'd0);
        chk("same.req", {31'd0, imem_req}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        chk_req("same.reissue", 1'b1, 11'h123);
        step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
        chk_head("same.first", 1'b1, 11'h123);

        // Clear mid-request; a late ack must be ignored.
        step(1'b1, 1'b0, 1'b0, 1'b0, 11'd0);
        chk_req("clr", 1'b0, 11'd0);
        chk_head("clr", 1'b0, 11'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 11'd0);
        chk_req("clr.late", 1'b1, 11'd0);
        chk_head("clr.late", 1'b0, 11'd0);

        // Random run: the presented stream must be consecutive from the last redirect.
        exp_pc    = 11'd0;
        prev_req  = imem_req;
        prev_ack  = 1'b0;
        prev_addr = imem_addr;
        starve    = 0;
        for (int c = 0; c < 3000; c++) begin
            f_r  = ($urandom_range(0, 3) != 0);
            a_r  = imem_req && ($urandom_range(0, 2) == 0);
            j_r  = ($urandom_range(0, 24) == 0);
            ja_r = ($urandom_range(0, 3) == 0) ? 11'(11'h7FD + 11'($urandom_range(0, 3)))
                                               : 11'($urandom_range(0, 2047));
            prev_req  = imem_req;
            prev_ack  = a_r;
            prev_addr = imem_addr;
            if (j_r) exp_pc = ja_r;
            else if (f_r && instr_valid) exp_pc = exp_pc + 11'd1;
            step(1'b0, f_r, a_r, j_r, ja_r);

            if (prev_req && !prev_ack) begin
                chk("rnd.hold.req", {31'd0, imem_req}, 32'd1);
                chk("rnd.hold.addr", {21'd0, imem_addr}, {21'd0, prev_addr});
            end
            if (j_r) begin
                chk("rnd.jump.flush", {31'd0, instr_valid}, 32'd0);
                starve = 0;
            end else begin
                chk_head("rnd", instr_valid, exp_pc);
                starve = instr_valid ? 0 : starve + 1;
            end
            if (starve > 60) begin
                chk("rnd.starved", 32'd0, 32'd1);
                starve = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
